// File: rtl/traffic_light_actuated_if.sv
// Sensor, request and lamp signals of the actuated two-road controller.
// The master modport drives the inputs; the controller uses the slave modport.
interface traffic_light_actuated_if;
    logic       SA;
    logic       SB;
    logic       PREQ_A;
    logic       PREQ_B;
    logic       NIGHT;
    logic [1:0] A;
    logic [1:0] B;
    logic [1:0] PA;
    logic [1:0] PB;

    modport master (
        output SA, SB, PREQ_A, PREQ_B, NIGHT,
        input  A, B, PA, PB
    );

    modport slave (
        input  SA, SB, PREQ_A, PREQ_B, NIGHT,
        output A, B, PA, PB
    );
endinterface

// File: rtl/traffic_light_actuated.sv
// Actuated two-road intersection controller with latched demand, green extension,
// pedestrian walk/flashing signals and a night flashing mode.
module traffic_light_actuated #(
    parameter int unsigned CNT_W       = 5,
    parameter int unsigned T_GREEN_MIN = 14,
    parameter int unsigned T_GREEN_MAX = 30,
    parameter int unsigned T_YELLOW    = 5,
    parameter int unsigned T_ALL_RED   = 3,
    parameter int unsigned T_WALK      = 8
) (
    input logic                     CLK,
    input logic                     RST,
    traffic_light_actuated_if.slave bus
);

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;
    localparam logic [1:0] BLINK  = 2'b11;

    localparam logic [2:0] A_GREEN  = 3'd0;
    localparam logic [2:0] A_YELLOW = 3'd1;
    localparam logic [2:0] AR_AB    = 3'd2;
    localparam logic [2:0] B_GREEN  = 3'd3;
    localparam logic [2:0] B_YELLOW = 3'd4;
    localparam logic [2:0] AR_BA    = 3'd5;
    localparam logic [2:0] FLASH    = 3'd6;

    localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(T_GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(T_GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(T_ALL_RED - 1);
    localparam logic [CNT_W-1:0] WALK_LEN  = CNT_W'(T_WALK);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             dem_a_q, dem_a_d;
    logic             dem_b_q, dem_b_d;
    logic [1:0]       a_d, b_d, pa_d, pb_d;
    logic             req_a, req_b;
    logic             want_b, want_a;

    assign req_a = bus.SA | bus.PREQ_A;
    assign req_b = bus.SB | bus.PREQ_B;

    // A request arriving this cycle counts as demand at once, as if already latched.
    assign want_b = dem_b_q | req_b | bus.NIGHT;
    assign want_a = dem_a_q | req_a | bus.NIGHT;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            A_GREEN: begin
                if (count_q >= GMIN_LAST && want_b && (!bus.SA || count_q >= GMAX_LAST)) begin
                    state_d = A_YELLOW;
                end
            end
            A_YELLOW: if (count_q == YEL_LAST) state_d = AR_AB;
            AR_AB:    if (count_q == AR_LAST) state_d = bus.NIGHT ? FLASH : B_GREEN;
            B_GREEN: begin
                if (count_q >= GMIN_LAST && want_a && (!bus.SB || count_q >= GMAX_LAST)) begin
                    state_d = B_YELLOW;
                end
            end
            B_YELLOW: if (count_q == YEL_LAST) state_d = AR_BA;
            AR_BA:    if (count_q == AR_LAST) state_d = bus.NIGHT ? FLASH : A_GREEN;
            FLASH:    if (!bus.NIGHT) state_d = AR_BA;
            default:  state_d = A_GREEN;
        endcase
    end

    always_comb begin
        if (state_d != state_q) begin
            count_d = '0;
        end else if (count_q == GMAX_LAST) begin
            count_d = count_q;
        end else begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Entering a green clears that road's latch even if a request arrives on the same edge.
    always_comb begin
        dem_a_d = dem_a_q | req_a;
        dem_b_d = dem_b_q | req_b;
        if (state_d == A_GREEN && state_q != A_GREEN) dem_a_d = 1'b0;
        if (state_d == B_GREEN && state_q != B_GREEN) dem_b_d = 1'b0;
    end

    always_comb begin
        a_d  = RED;
        b_d  = RED;
        pa_d = RED;
        pb_d = RED;
        unique case (state_d)
            A_GREEN: begin
                a_d  = GREEN;
                pa_d = (count_d < WALK_LEN) ? GREEN : BLINK;
            end
            A_YELLOW: a_d = YELLOW;
            B_GREEN: begin
                b_d  = GREEN;
                pb_d = (count_d < WALK_LEN) ? GREEN : BLINK;
            end
            B_YELLOW: b_d = YELLOW;
            FLASH: begin
                a_d = BLINK;
                b_d = BLINK;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= A_GREEN;
            count_q <= '0;
            dem_a_q <= 1'b0;
            dem_b_q <= 1'b0;
            bus.A   <= GREEN;
            bus.B   <= RED;
            bus.PA  <= GREEN;
            bus.PB  <= RED;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            dem_a_q <= dem_a_d;
            dem_b_q <= dem_b_d;
            bus.A   <= a_d;
            bus.B   <= b_d;
            bus.PA  <= pa_d;
            bus.PB  <= pb_d;
        end
    end

endmodule

// File: tb/tb_traffic_light_actuated.sv
// Scoreboard bench: directed scenarios push hand-computed per-cycle lamp expectations,
// and a negedge monitor pops and compares them against the controller outputs.
module tb_traffic_light_actuated;

    localparam logic [1:0] RED = 2'b00;
    localparam logic [1:0] YEL = 2'b01;
    localparam logic [1:0] GRN = 2'b10;
    localparam logic [1:0] BLK = 2'b11;

    typedef struct {
        logic [7:0] lamps;
        int         cnt;
        int         dem;
        int         scen;
        int         cyc;
    } exp_t;

    logic CLK;
    logic RST;
    int   checks;
    int   failures;
    exp_t sb[$];
    exp_t e;

    traffic_light_actuated_if tl ();

    traffic_light_actuated dut (
        .CLK (CLK),
        .RST (RST),
        .bus (tl.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [1:0] ped(int k);
        return (k < 8) ? GRN : BLK;
    endfunction

    task automatic push(int s, int c, logic [1:0] a, logic [1:0] b, logic [1:0] pa,
                        logic [1:0] pb, int cnt, int dem);
        exp_t x;
        x.lamps = {a, b, pa, pb};
        x.cnt   = cnt;
        x.dem   = dem;
        x.scen  = s;
        x.cyc   = c;
        sb.push_back(x);
    endtask

    task automatic set_in(logic sa, logic sbv, logic pa, logic pb, logic night);
        tl.SA     = sa;
        tl.SB     = sbv;
        tl.PREQ_A = pa;
        tl.PREQ_B = pb;
        tl.NIGHT  = night;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Leaves the bench at the start of cycle 0, just after the reset edge.
    task automatic start();
        RST = 1'b1;
        set_in(0, 0, 0, 0, 0);
        tick();
        RST = 1'b0;
    endtask

    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({tl.A, tl.B, tl.PA, tl.PB} !== e.lamps) begin
                failures++;
                $display("FAIL lamps s%0d c%0d: got A=%0d B=%0d PA=%0d PB=%0d, want A=%0d B=%0d PA=%0d PB=%0d",
                         e.scen, e.cyc, tl.A, tl.B, tl.PA, tl.PB,
                         e.lamps[7:6], e.lamps[5:4], e.lamps[3:2], e.lamps[1:0]);
            end
            if (e.cnt >= 0) begin
                checks++;
                if (int'(dut.count_q) != e.cnt) begin
                    failures++;
                    $display("FAIL count s%0d c%0d: got %0d, want %0d",
                             e.scen, e.cyc, dut.count_q, e.cnt);
                end
            end
            if (e.dem >= 0) begin
                checks++;
                if (int'({dut.dem_a_q, dut.dem_b_q}) != e.dem) begin
                    failures++;
                    $display("FAIL demand s%0d c%0d: got dem_a=%0b dem_b=%0b, want %0d",
                             e.scen, e.cyc, dut.dem_a_q, dut.dem_b_q, e.dem);
                end
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;

        // 1: SB held -> minimum green, yellow, all-red, B green at 22.
        start();
        for (int c = 0; c <= 22; c++) begin
            set_in(0, 1, 0, 0, 0);
            if (c < 14)      push(1, c, GRN, RED, ped(c), RED, (c == 0) ? 0 : -1, (c == 0) ? 0 : -1);
            else if (c < 19) push(1, c, YEL, RED, RED, RED, -1, -1);
            else if (c < 22) push(1, c, RED, RED, RED, RED, -1, -1);
            else             push(1, c, RED, GRN, RED, GRN, 0, 0);
            tick();
        end

        // 2: no demand -> rest in A green, counter saturates at 29.
        start();
        for (int c = 0; c < 100; c++) begin
            set_in(0, 0, 0, 0, 0);
            push(2, c, GRN, RED, ped(c), RED, (c < 29) ? c : 29, -1);
            tick();
        end

        // 3: SA held, single PREQ_B pulse -> extension to the 30-cycle maximum.
        start();
        for (int c = 0; c <= 30; c++) begin
            set_in(1, 0, 0, c == 3, 0);
            if (c < 30) push(3, c, GRN, RED, ped(c), RED, -1, (c == 0) ? 0 : (c < 4) ? 2 : 3);
            else        push(3, c, YEL, RED, RED, RED, 0, 3);
            tick();
        end

        // 4: late SB pulse -> yellow at 21, B green at 29 with its latch cleared.
        start();
        for (int c = 0; c <= 29; c++) begin
            set_in(0, c == 20, 0, 0, 0);
            if (c <= 20)     push(4, c, GRN, RED, ped(c), RED, -1, 0);
            else if (c < 26) push(4, c, YEL, RED, RED, RED, -1, 1);
            else if (c < 29) push(4, c, RED, RED, RED, RED, -1, 1);
            else             push(4, c, RED, GRN, RED, GRN, 0, 0);
            tick();
        end

        // 5: night mode -> flash from 22, released at 40, A green at 44.
        start();
        for (int c = 0; c <= 44; c++) begin
            set_in(0, 0, 0, 0, c < 40);
            if (c < 14)      push(5, c, GRN, RED, ped(c), RED, -1, -1);
            else if (c < 19) push(5, c, YEL, RED, RED, RED, -1, -1);
            else if (c < 22) push(5, c, RED, RED, RED, RED, -1, -1);
            else if (c < 41) push(5, c, BLK, BLK, RED, RED, (c == 40) ? 18 : -1, -1);
            else if (c < 44) push(5, c, RED, RED, RED, RED, -1, -1);
            else             push(5, c, GRN, RED, GRN, RED, 0, -1);
            tick();
        end

        // 6: reset in B yellow at count 2 -> reset state on the next cycle.
        start();
        for (int c = 0; c <= 40; c++) begin
            RST = (c == 38);
            if (c < 39) set_in(c >= 22, c < 22, 0, 0, 0);
            else        set_in(0, 0, 0, 0, 0);
            if (c < 14)      push(6, c, GRN, RED, ped(c), RED, -1, -1);
            else if (c < 19) push(6, c, YEL, RED, RED, RED, -1, -1);
            else if (c < 22) push(6, c, RED, RED, RED, RED, -1, -1);
            else if (c < 36) push(6, c, RED, GRN, RED, ped(c - 22), -1, -1);
            else if (c < 39) push(6, c, RED, YEL, RED, RED, c - 36, -1);
            else if (c == 39) push(6, c, GRN, RED, GRN, RED, 0, 0);
            else             push(6, c, GRN, RED, GRN, RED, 1, 0);
            tick();
        end
        RST = 1'b0;

        tick();
        tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d expectations left, want 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
